// File: rtl/uut_clk_sequencer.sv
// UUT clock sequencer: programmable-ratio clock enable and divided clock with
// free-run, burst and single-step modes, tick counting and latency capture.
module uut_clk_sequencer #(
  parameter int DIV_WIDTH = 8,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           mode,
  input  logic [DIV_WIDTH-1:0] div_sel,
  input  logic [CNT_WIDTH-1:0] burst_len,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 end_uut,
  output logic                 clk_en,
  output logic                 clk_div,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] tick_count,
  output logic [CNT_WIDTH-1:0] latency,
  output logic                 lat_valid
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [1:0] MODE_STOP  = 2'b00;
  localparam logic [1:0] MODE_BURST = 2'b10;
  localparam logic [1:0] MODE_STEP  = 2'b11;

  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] phase_q, phase_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [1:0]           mode_q, mode_d;
  logic [CNT_WIDTH-1:0] len_q, len_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] lat_q, lat_d;
  logic                 latv_q, latv_d;
  logic                 clk_en_q, clk_div_q, busy_q, done_q;
  logic                 clk_en_d, clk_div_d, run_d;
  logic                 tick;
  logic [CNT_WIDTH-1:0] cnt_inc;

  // A zero-length burst never ticks; it only spends one cycle in RUN.
  assign tick    = (state_q == RUN) && (phase_q == div_q) &&
                   !((mode_q == MODE_BURST) && (len_q == '0));
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    div_d   = div_q;
    mode_d  = mode_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    latv_d  = latv_q;
    case (state_q)
      IDLE: begin
        if (start && (mode != MODE_STOP)) begin
          state_d = RUN;
          mode_d  = mode;
          div_d   = div_sel;
          len_d   = burst_len;
          phase_d = '0;
          cnt_d   = '0;
          lat_d   = '0;
          latv_d  = 1'b0;
        end
      end
      RUN: begin
        if (end_uut && !latv_q) begin
          lat_d  = cnt_q;
          latv_d = 1'b1;
        end
        // The ratio is only re-sampled at a period boundary.
        if (tick) begin
          cnt_d   = cnt_inc;
          phase_d = '0;
          div_d   = div_sel;
        end else begin
          phase_d = phase_q + 1'b1;
        end
        if (stop ||
            ((mode_q == MODE_STEP) && tick && (cnt_inc == CNT_WIDTH'(1))) ||
            ((mode_q == MODE_BURST) && ((len_q == '0) || (tick && (cnt_inc == len_q)))))
          state_d = DONE;
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase
  end

  // Outputs are predicted from next-state values so they can be flop outputs.
  always_comb begin
    run_d     = (state_d == RUN);
    clk_en_d  = run_d && (phase_d == div_d) && !((mode_d == MODE_BURST) && (len_d == '0));
    clk_div_d = run_d && ((div_d == '0) || (phase_d <= (div_d >> 1)));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      div_q     <= '0;
      mode_q    <= MODE_STOP;
      len_q     <= '0;
      cnt_q     <= '0;
      lat_q     <= '0;
      latv_q    <= 1'b0;
      clk_en_q  <= 1'b0;
      clk_div_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      div_q     <= div_d;
      mode_q    <= mode_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      lat_q     <= lat_d;
      latv_q    <= latv_d;
      clk_en_q  <= clk_en_d;
      clk_div_q <= clk_div_d;
      busy_q    <= run_d;
      done_q    <= (state_d == DONE);
    end
  end

  assign clk_en     = clk_en_q;
  assign clk_div    = clk_div_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign tick_count = cnt_q;
  assign latency    = lat_q;
  assign lat_valid  = latv_q;

endmodule

// File: tb/tb_uut_clk_sequencer.sv
// Directed bench for uut_clk_sequencer; cycle numbers are counted from the
// cycle in which start is presented (cycle 0), RUN begins in cycle 1.
module tb_uut_clk_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic [7:0]  div_sel;
  logic [31:0] burst_len;
  logic        start, stop, end_uut;
  logic        clk_en, clk_div, busy, done, lat_valid;
  logic [31:0] tick_count, latency;

  int n_checks = 0;
  int n_fail   = 0;

  uut_clk_sequencer #(.DIV_WIDTH(8), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .mode(mode), .div_sel(div_sel), .burst_len(burst_len),
    .start(start), .stop(stop), .end_uut(end_uut),
    .clk_en(clk_en), .clk_div(clk_div), .busy(busy), .done(done),
    .tick_count(tick_count), .latency(latency), .lat_valid(lat_valid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [1:0] m, input logic [7:0] d, input logic [31:0] len);
    mode = m; div_sel = d; burst_len = len; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_clk_en"}, {31'd0, clk_en}, 32'd0);
    chk({tag, "_clk_div"}, {31'd0, clk_div}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_tick_count"}, tick_count, 32'd0);
    chk({tag, "_latency"}, latency, 32'd0);
    chk({tag, "_lat_valid"}, {31'd0, lat_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; mode = 2'b00; div_sel = 8'd0; burst_len = 32'd0;
    start = 1'b0; stop = 1'b0; end_uut = 1'b0;
    step(); step();
    chk_all_zero("reset");
    rst = 1'b1;
    step();

    // start with mode 00 must not launch a run
    mode = 2'b00; start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("mode0_ignored_busy", {31'd0, busy}, 32'd0);

    // Free-run, div 0: ticks every RUN cycle, stop in cycle 10
    launch(2'b01, 8'd0, 32'd0);
    for (int c = 1; c <= 10; c++) begin
      chk($sformatf("fr_en_c%0d", c), {31'd0, clk_en}, 32'd1);
      chk($sformatf("fr_div_c%0d", c), {31'd0, clk_div}, 32'd1);
      chk($sformatf("fr_cnt_c%0d", c), tick_count, 32'(c - 1));
      if (c == 10) stop = 1'b1;
      step();
    end
    stop = 1'b0;
    chk("fr_done", {31'd0, done}, 32'd1);
    chk("fr_busy_done", {31'd0, busy}, 32'd0);
    chk("fr_en_done", {31'd0, clk_en}, 32'd0);
    chk("fr_clkdiv_done", {31'd0, clk_div}, 32'd0);
    chk("fr_tick_count", tick_count, 32'd10);
    step();
    chk("fr_done_gone", {31'd0, done}, 32'd0);

    // Burst, div 3, len 4: ticks in cycles 4,8,12,16; clk_div 1,1,0,0
    launch(2'b10, 8'd3, 32'd4);
    for (int c = 1; c <= 16; c++) begin
      chk($sformatf("b4_en_c%0d", c), {31'd0, clk_en}, {31'd0, (c % 4) == 0});
      chk($sformatf("b4_div_c%0d", c), {31'd0, clk_div}, {31'd0, ((c - 1) % 4) < 2});
      chk($sformatf("b4_busy_c%0d", c), {31'd0, busy}, 32'd1);
      step();
    end
    chk("b4_done", {31'd0, done}, 32'd1);
    chk("b4_tick_count", tick_count, 32'd4);
    chk("b4_busy_done", {31'd0, busy}, 32'd0);
    step();
    chk("b4_done_gone", {31'd0, done}, 32'd0);
    chk("b4_busy_idle", {31'd0, busy}, 32'd0);
    chk("b4_tick_held", tick_count, 32'd4);

    // Step, div 2: one tick in cycle 3, done in cycle 4
    launch(2'b11, 8'd2, 32'd0);
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("st_en_c%0d", c), {31'd0, clk_en}, {31'd0, c == 3});
      step();
    end
    chk("st_done", {31'd0, done}, 32'd1);
    chk("st_tick_count", tick_count, 32'd1);
    chk("st_en_done", {31'd0, clk_en}, 32'd0);
    step();

    // Burst of length 0 (div 0): one RUN cycle, no tick
    launch(2'b10, 8'd0, 32'd0);
    chk("b0_en", {31'd0, clk_en}, 32'd0);
    chk("b0_busy", {31'd0, busy}, 32'd1);
    step();
    chk("b0_done", {31'd0, done}, 32'd1);
    chk("b0_tick_count", tick_count, 32'd0);
    chk("b0_en_done", {31'd0, clk_en}, 32'd0);
    step();

    // Ratio change 3 -> 1 in cycle 6: ticks at 4, 8, then 10, 12, 14
    launch(2'b01, 8'd3, 32'd0);
    for (int c = 1; c <= 14; c++) begin
      if (c == 6) div_sel = 8'd1;
      chk($sformatf("rc_en_c%0d", c), {31'd0, clk_en},
          {31'd0, (c == 4) || (c == 8) || (c == 10) || (c == 12) || (c == 14)});
      if (c == 14) stop = 1'b1;
      step();
    end
    stop = 1'b0;
    chk("rc_done", {31'd0, done}, 32'd1);
    chk("rc_tick_count", tick_count, 32'd5);
    step();

    // Latency: burst len 8 div 1, end_uut in cycle 11 (count 5) and cycle 15 (count 7)
    launch(2'b10, 8'd1, 32'd8);
    for (int c = 1; c <= 16; c++) begin
      end_uut = (c == 11) || (c == 15);
      chk($sformatf("lt_en_c%0d", c), {31'd0, clk_en}, {31'd0, (c % 2) == 0});
      if (c == 11) chk("lt_valid_before", {31'd0, lat_valid}, 32'd0);
      if (c == 12) begin
        chk("lt_latency_first", latency, 32'd5);
        chk("lt_valid_first", {31'd0, lat_valid}, 32'd1);
      end
      step();
    end
    end_uut = 1'b0;
    chk("lt_latency_second", latency, 32'd5);
    chk("lt_done", {31'd0, done}, 32'd1);
    chk("lt_tick_count", tick_count, 32'd8);
    step();
    end_uut = 1'b1;
    step();
    end_uut = 1'b0;
    chk("lt_latency_idle", latency, 32'd5);
    chk("lt_valid_idle", {31'd0, lat_valid}, 32'd1);
    chk("lt_tick_idle", tick_count, 32'd8);

    // Next start clears capture; reset mid-burst after the 2nd tick
    launch(2'b10, 8'd1, 32'd4);
    chk("rs_latency_cleared", latency, 32'd0);
    chk("rs_valid_cleared", {31'd0, lat_valid}, 32'd0);
    chk("rs_tick_cleared", tick_count, 32'd0);
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("rs_en_c%0d", c), {31'd0, clk_en}, {31'd0, (c % 2) == 0});
      step();
    end
    chk("rs_tick_before", tick_count, 32'd2);
    chk("rs_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk_all_zero("rs_after");

    // Complete burst after reset: div 2, len 3 -> ticks at 3, 6, 9
    launch(2'b10, 8'd2, 32'd3);
    for (int c = 1; c <= 9; c++) begin
      chk($sformatf("pr_en_c%0d", c), {31'd0, clk_en}, {31'd0, (c % 3) == 0});
      chk($sformatf("pr_div_c%0d", c), {31'd0, clk_div}, {31'd0, ((c - 1) % 3) < 2});
      step();
    end
    chk("pr_done", {31'd0, done}, 32'd1);
    chk("pr_tick_count", tick_count, 32'd3);
    step();
    chk("pr_done_gone", {31'd0, done}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uut_clk_sequencer.md
Name: uut_clk_sequencer

Overview:
- Parametrised successor to the fixed-choice UUT clock generator in the autotest harness.
- Runs in the single system clock domain and produces a programmable-ratio clock-enable plus a registered divided clock for the UUT.
- Supports free-run, counted-burst and single-step modes, with ratio changes applied only at period boundaries.
- Counts issued UUT ticks and captures the tick count at end_uut for performance measurement by the control unit.

Parameters:
DIV_WIDTH, 8, width of divide-ratio field; tick period = div+1 clk cycles
CNT_WIDTH, 32, width of burst length, tick counter and latency capture

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-low
mode  in  2  00 stop, 01 free-run, 10 burst, 11 step
div_sel  in  DIV_WIDTH  divide ratio; sampled at start and at every tick
burst_len  in  CNT_WIDTH  ticks to issue in burst mode; sampled at start
start  in  1  launch request, level-sampled
stop  in  1  abort run
end_uut  in  1  UUT completion flag
clk_en  out  1  one-cycle enable, one per UUT tick
clk_div  out  1  divided UUT clock, flop output
busy  out  1  run in progress
done  out  1  one-cycle completion pulse
tick_count  out  CNT_WIDTH  ticks issued since last start
latency  out  CNT_WIDTH  tick_count captured at first end_uut of a run
lat_valid  out  1  latency holds a valid capture

Behaviour:
- Reset (rst==0 at a clk edge) forces the following from the next cycle, including mid-run:
  - state IDLE; phase 0
  - all outputs 0, including tick_count and latency
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start==1 with mode!=00: latch mode_l, div_l=div_sel, len_l=burst_len; clear phase, tick_count, latency, lat_valid; go RUN.
  - start with mode==00 is ignored.
- RUN:
  - busy=1.
  - phase counts 0..div_l, then wraps to 0.
  - clk_en=1 exactly in cycles where phase==div_l, so the first pulse is in the (div_l+1)th RUN cycle. div_l==0 gives clk_en every cycle.
  - Each tick increments tick_count, saturating at all-ones.
  - div_l reloads from div_sel only on a tick cycle; the new ratio governs the next period. Mid-period changes never shorten or stretch the current period.
  - clk_div:
    - div_l==0: held 1.
    - otherwise: 1 for phase 0..floor(div_l/2), 0 for the remaining phases.
    - Registered; must never glitch.
  - Exit conditions:
    - step: after the tick that brings tick_count to 1, go DONE.
    - burst: after the tick that brings tick_count to len_l, go DONE. len_l==0 goes DONE on the first RUN cycle with no tick.
    - free-run: runs until stop.
  - stop==1: go DONE next cycle. A tick coincident with stop is still issued and counted; no further ticks.
  - start during RUN is ignored. mode and burst_len changes during RUN are ignored.
- DONE:
  - done=1, busy=0, clk_en=0, clk_div=0 for one cycle; then IDLE.
  - start in DONE is ignored.
- Latency capture:
  - First cycle with end_uut==1 while busy: latency <= tick_count register value in that cycle (excludes a coincident tick); lat_valid <= 1.
  - Later end_uut assertions are ignored until the next start.
  - end_uut outside RUN is ignored.
- tick_count, latency and lat_valid hold their values in IDLE until the next start or reset.
- No combinational path from any input to any output.

Test Plan:
- Free-run, div_sel=0: start at cycle 0, stop at cycle 10 → clk_en high in cycles 1..10; done at cycle 11; tick_count=10; clk_div constant 1 while busy.
- Burst, div_sel=3, burst_len=4 → clk_en at RUN cycles 4, 8, 12, 16; clk_div pattern 1,1,0,0 per period; done one cycle after the 4th tick; tick_count=4; busy low afterwards.
- Step, div_sel=2 → single clk_en on RUN cycle 3; tick_count=1; done next cycle. Burst with burst_len=0 → done with tick_count=0 and no clk_en.
- Ratio change: free-run div_sel=3, change to div_sel=1 mid-way through the 2nd period → that period still lasts 4 cycles; following ticks every 2 cycles.
- Latency: burst len=8, div=1, end_uut pulsed after the 5th tick, then again after the 7th → latency=5, lat_valid=1, unchanged by the second pulse; cleared by the next start.
- Reset mid-burst (rst=0 for one cycle after the 2nd tick) → all outputs 0 next cycle, state IDLE; a subsequent start runs a complete, correct burst.
